// File: rtl/flash_boot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_boot_pkg
// Description : Shared state encoding and default parameters for the boot
//               copy engine.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FL_REQ = 3'd1,
        SR_WR  = 3'd2,
        FL_GAP = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam int unsigned c_DEF_WORDS    = 32768;
    localparam logic [16:0] c_DEF_SRC_BASE = 17'h00000;
    localparam logic [18:0] c_DEF_DST_BASE = 19'h78000;
    localparam int unsigned c_DEF_TIMEOUT  = 255;

    // Wait counter width: wide enough for TIMEOUT, never narrower than 8 bits.
    function automatic int unsigned wdog_width(input int unsigned timeout);
        return ($clog2(timeout + 1) > 8) ? $clog2(timeout + 1) : 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/flash_boot_copier_wdog.sv
`default_nettype none
// ============================================================================
// Module      : boot_wdog
// Description : Per-state ack wait counter; flags the TIMEOUT-th waiting cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module boot_wdog
    import flash_boot_pkg::*;
#(
    parameter int unsigned TIMEOUT = c_DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned      c_W       = wdog_width(TIMEOUT);
    localparam logic [c_W-1:0]   c_TIMEOUT = c_W'(TIMEOUT);

    logic [c_W-1:0] r_cnt;
    logic [c_W-1:0] w_count;

    // r_cnt holds completed waiting cycles; w_count numbers the cycle in
    // progress, so expiry lands on the edge that closes the TIMEOUT-th cycle.
    assign w_count   = r_cnt + 1'b1;
    assign o_expired = i_en && (w_count == c_TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_count;
        end
    end

endmodule
`default_nettype wire

// File: rtl/flash_boot_copier.sv
`default_nettype none
// ============================================================================
// Module      : flash_boot_copier
// Description : Copies a BIOS image from flash to SRAM after reset, holding
//               the CPU in reset until done; reports checksum and timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_boot_copier
    import flash_boot_pkg::*;
#(
    parameter int unsigned WORDS    = c_DEF_WORDS,
    parameter logic [16:0] SRC_BASE = c_DEF_SRC_BASE,
    parameter logic [18:0] DST_BASE = c_DEF_DST_BASE,
    parameter int unsigned TIMEOUT  = c_DEF_TIMEOUT
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    output logic        fl_stb_o,
    output logic [16:0] fl_adr_o,
    output logic        fl_byte_o,
    input  logic [15:0] fl_dat_i,
    input  logic        fl_ack_i,
    output logic        sr_cyc_o,
    output logic        sr_stb_o,
    output logic        sr_we_o,
    output logic [18:0] sr_adr_o,
    output logic [1:0]  sr_sel_o,
    output logic [15:0] sr_dat_o,
    input  logic        sr_ack_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] csum_o
);

    localparam logic [15:0] c_LAST_CNT = 16'(WORDS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_cnt;
    logic        r_fl_stb;
    logic [16:0] r_fl_adr;
    logic        r_sr_stb;
    logic [18:0] r_sr_adr;
    logic [15:0] r_sr_dat;
    logic        r_cpu_rst;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_csum;

    logic w_wd_clr;
    logic w_wd_en;
    logic w_expired;
    logic w_fl_stb;
    logic w_sr_stb;
    logic w_cpu_rst;
    logic w_done;
    logic w_err;
    logic w_fl_load;
    logic w_sr_load;
    logic w_sum_add;
    logic w_cnt_inc;

    assign w_wd_clr = (w_next != r_state);
    assign w_wd_en  = (r_state == FL_REQ) || (r_state == SR_WR);

    boot_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ack arriving on the expiry cycle still counts as a response.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   w_next = FL_REQ;
            FL_REQ: begin
                if (fl_ack_i) begin
                    w_next = SR_WR;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            SR_WR: begin
                if (sr_ack_i) begin
                    w_next = (r_cnt == c_LAST_CNT) ? DONE : FL_GAP;
                end else if (w_expired) begin
                    w_next = ERR;
                end
            end
            FL_GAP: begin
                if (!fl_ack_i) begin
                    w_next = FL_REQ;
                end
            end
            DONE:    w_next = DONE;
            ERR:     w_next = ERR;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state and registered below.
    always_comb begin
        w_fl_stb  = (w_next == FL_REQ);
        w_sr_stb  = (w_next == SR_WR);
        w_done    = (w_next == DONE);
        w_err     = (w_next == ERR);
        w_cpu_rst = (w_next != DONE);
        w_fl_load = (w_next == FL_REQ) && (r_state != FL_REQ);
        w_sr_load = (r_state == FL_REQ) && fl_ack_i;
        w_sum_add = (r_state == SR_WR) && sr_ack_i;
        w_cnt_inc = w_sum_add && (r_cnt != c_LAST_CNT);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt     <= '0;
            r_fl_stb  <= 1'b0;
            r_fl_adr  <= '0;
            r_sr_stb  <= 1'b0;
            r_sr_adr  <= '0;
            r_sr_dat  <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_csum    <= '0;
        end else begin
            r_fl_stb  <= w_fl_stb;
            r_sr_stb  <= w_sr_stb;
            r_cpu_rst <= w_cpu_rst;
            r_done    <= w_done;
            r_err     <= w_err;
            if (w_fl_load) begin
                r_fl_adr <= SRC_BASE + {r_cnt, 1'b0};
            end
            if (w_sr_load) begin
                r_sr_adr <= DST_BASE + 19'(r_cnt);
                r_sr_dat <= fl_dat_i;
            end
            if (w_sum_add) begin
                r_csum <= r_csum + r_sr_dat;
            end
            if (w_cnt_inc) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign fl_stb_o  = r_fl_stb;
    assign fl_adr_o  = r_fl_adr;
    assign fl_byte_o = 1'b0;
    assign sr_cyc_o  = r_sr_stb;
    assign sr_stb_o  = r_sr_stb;
    assign sr_we_o   = r_sr_stb;
    assign sr_sel_o  = {2{r_sr_stb}};
    assign sr_adr_o  = r_sr_adr;
    assign sr_dat_o  = r_sr_dat;
    assign cpu_rst_o = r_cpu_rst;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign csum_o    = r_csum;

endmodule
`default_nettype wire

// File: tb/tb_flash_boot_copier.sv
`default_nettype none
// ============================================================================
// Module      : tb_flash_boot_copier
// Description : Self-checking bench for flash_boot_copier (4-word and 1-word).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_flash_boot_copier;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // ---------------- DUT A: 4 words, TIMEOUT 10 ----------------
    logic        a_fl_stb, a_fl_byte, a_fl_ack;
    logic [16:0] a_fl_adr;
    logic [15:0] a_fl_dat;
    logic        a_sr_cyc, a_sr_stb, a_sr_we, a_sr_ack;
    logic [18:0] a_sr_adr;
    logic [1:0]  a_sr_sel;
    logic [15:0] a_sr_dat;
    logic        a_cpu_rst, a_done, a_err;
    logic [15:0] a_csum;

    flash_boot_copier #(
        .WORDS(4), .SRC_BASE(17'h00000), .DST_BASE(19'h78000), .TIMEOUT(10)
    ) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .fl_stb_o(a_fl_stb), .fl_adr_o(a_fl_adr), .fl_byte_o(a_fl_byte),
        .fl_dat_i(a_fl_dat), .fl_ack_i(a_fl_ack),
        .sr_cyc_o(a_sr_cyc), .sr_stb_o(a_sr_stb), .sr_we_o(a_sr_we),
        .sr_adr_o(a_sr_adr), .sr_sel_o(a_sr_sel), .sr_dat_o(a_sr_dat),
        .sr_ack_i(a_sr_ack),
        .cpu_rst_o(a_cpu_rst), .done_o(a_done), .err_o(a_err), .csum_o(a_csum)
    );

    // Flash and SRAM models for DUT A
    int unsigned fl_hold  = 0;
    logic        fl_never = 1'b0;
    int unsigned sr_delay = 0;
    int unsigned hold_cnt = 0;
    int unsigned sr_wait  = 0;

    always @(posedge clk) begin
        if (a_fl_stb) hold_cnt <= fl_hold;
        else if (hold_cnt != 0) hold_cnt <= hold_cnt - 1;
        if (a_sr_stb && !a_sr_ack) sr_wait <= sr_wait + 1;
        else sr_wait <= 0;
    end
    assign a_fl_ack = !fl_never && (a_fl_stb || hold_cnt != 0);
    assign a_fl_dat = 16'h1111 * (a_fl_adr[16:1] + 16'd1);
    assign a_sr_ack = a_sr_stb && (sr_wait == sr_delay);

    // ---------------- DUT B: 1 word, data FFFF ----------------
    logic        b_fl_stb, b_fl_byte;
    logic [16:0] b_fl_adr;
    logic        b_sr_cyc, b_sr_stb, b_sr_we;
    logic [18:0] b_sr_adr;
    logic [1:0]  b_sr_sel;
    logic [15:0] b_sr_dat;
    logic        b_cpu_rst, b_done, b_err;
    logic [15:0] b_csum;
    logic [15:0] b_fl_dat;
    assign b_fl_dat = 16'hFFFF;

    flash_boot_copier #(
        .WORDS(1), .SRC_BASE(17'h00000), .DST_BASE(19'h78000), .TIMEOUT(10)
    ) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .fl_stb_o(b_fl_stb), .fl_adr_o(b_fl_adr), .fl_byte_o(b_fl_byte),
        .fl_dat_i(b_fl_dat), .fl_ack_i(b_fl_stb),
        .sr_cyc_o(b_sr_cyc), .sr_stb_o(b_sr_stb), .sr_we_o(b_sr_we),
        .sr_adr_o(b_sr_adr), .sr_sel_o(b_sr_sel), .sr_dat_o(b_sr_dat),
        .sr_ack_i(b_sr_stb),
        .cpu_rst_o(b_cpu_rst), .done_o(b_done), .err_o(b_err), .csum_o(b_csum)
    );

    int b_writes = 0;
    always @(negedge clk) begin
        if (rst) b_writes <= 0;
        else if (b_sr_stb) begin
            b_writes <= b_writes + 1;
            chk("b_sr_write", {b_sr_adr, b_sr_dat}, {19'h78000, 16'hFFFF});
        end
    end

    // ---------------- Scoreboards for DUT A ----------------
    logic [16:0] exp_fl_q[$];
    logic [34:0] exp_sr_q[$];
    logic        prev_fl_stb = 1'b0;
    logic        prev_sr_stb = 1'b0;
    logic [34:0] sr_snap     = '0;
    int unsigned sr_len      = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_fl_stb && !prev_fl_stb) begin
                chk("fl_ack_low_at_stb_rise", hold_cnt, 0);
                if (exp_fl_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL fl_adr: unexpected read at %0h, none required", a_fl_adr);
                end else begin
                    chk("fl_adr", a_fl_adr, exp_fl_q.pop_front());
                end
            end
            if (a_sr_stb && prev_sr_stb)
                chk("sr_stable", {a_sr_adr, a_sr_dat}, sr_snap);
            if (a_sr_stb && a_sr_ack) begin
                chk("sr_stb_len", prev_sr_stb ? sr_len + 1 : 1, sr_delay + 1);
                chk("sr_ctl", {a_sr_cyc, a_sr_we, a_sr_sel}, 4'b1111);
                if (exp_sr_q.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("FAIL sr_write: unexpected write %0h, none required", {a_sr_adr, a_sr_dat});
                end else begin
                    chk("sr_write", {a_sr_adr, a_sr_dat}, exp_sr_q.pop_front());
                end
            end
        end
        if (a_sr_stb && !prev_sr_stb) sr_snap <= {a_sr_adr, a_sr_dat};
        sr_len      <= a_sr_stb ? (prev_sr_stb ? sr_len + 1 : 1) : 0;
        prev_fl_stb <= a_fl_stb;
        prev_sr_stb <= a_sr_stb;
    end

    task automatic push_expected(input int words);
        exp_fl_q.delete();
        exp_sr_q.delete();
        for (int w = 0; w < words; w++) begin
            exp_fl_q.push_back(17'(2 * w));
            exp_sr_q.push_back({19'h78000 + 19'(w), 16'h1111 * 16'(w + 1)});
        end
    endtask

    task automatic wait_end(output int ea, output int eb);
        ea = -1;
        eb = -1;
        for (int i = 0; i < 200 && ea < 0; i++) begin
            @(posedge clk); #1;
            if (b_done && eb < 0) eb = i;
            if (a_done || a_err) ea = i;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_a_ctl"}, {a_cpu_rst, a_done, a_err, a_fl_stb, a_fl_byte,
                              a_sr_cyc, a_sr_stb, a_sr_we, a_sr_sel}, 10'b10_0000_0000);
        chk({tag, "_a_data"}, {a_fl_adr, a_sr_adr, a_sr_dat, a_csum}, 68'h0);
        chk({tag, "_b_ctl"}, {b_cpu_rst, b_done, b_err, b_fl_stb, b_sr_stb, b_csum}, 21'h100000);
    endtask

    typedef struct {
        int unsigned hold;
        int unsigned delay;
        int          done_edge;
        logic [15:0] csum;
    } vec_t;

    vec_t vecs[4];
    int   ea, eb;

    initial begin
        vecs[0] = '{0, 0, 11, 16'hAAAA};
        vecs[1] = '{5, 0, 23, 16'hAAAA};
        vecs[2] = '{0, 3, 23, 16'hAAAA};
        vecs[3] = '{2, 0, 14, 16'hAAAA};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");

        for (int v = 0; v < 4; v++) begin
            rst      = 1'b1;
            fl_never = 1'b0;
            fl_hold  = vecs[v].hold;
            sr_delay = vecs[v].delay;
            push_expected(4);
            repeat (8) @(posedge clk);
            #1;
            rst = 1'b0;
            wait_end(ea, eb);
            chk($sformatf("v%0d_done_edge", v), ea, vecs[v].done_edge);
            chk($sformatf("v%0d_csum", v), a_csum, vecs[v].csum);
            chk($sformatf("v%0d_flags", v), {a_done, a_cpu_rst, a_err, a_fl_stb, a_sr_stb}, 5'b10000);
            chk($sformatf("v%0d_left", v), exp_fl_q.size() + exp_sr_q.size(), 0);
            if (v == 0) begin
                chk("b_done_edge", eb, 2);
                chk("b_result", {b_done, b_cpu_rst, b_err, b_csum}, {3'b100, 16'hFFFF});
                chk("b_write_count", b_writes, 1);
            end
        end

        // Flash never acks
        rst      = 1'b1;
        fl_never = 1'b1;
        fl_hold  = 0;
        sr_delay = 0;
        push_expected(1);
        exp_sr_q.delete();
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_end(ea, eb);
        chk("to_err_edge", ea, 10);
        chk("to_flags", {a_err, a_fl_stb, a_cpu_rst, a_done, a_sr_stb}, 5'b10100);
        repeat (5) @(posedge clk);
        #1;
        chk("to_terminal", {a_err, a_fl_stb, a_cpu_rst, a_done}, 4'b1010);
        chk("to_left", exp_fl_q.size() + exp_sr_q.size(), 0);

        // Reset during word 2, then restart
        rst      = 1'b1;
        fl_never = 1'b0;
        push_expected(4);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 50 && !(a_fl_stb && a_fl_adr == 17'h4); i++) begin
            @(posedge clk); #1;
        end
        chk("mid_adr", {a_fl_stb, a_fl_adr}, {1'b1, 17'h4});
        chk("mid_csum", a_csum, 16'h3333);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("mid_reset");
        push_expected(4);
        rst = 1'b0;
        wait_end(ea, eb);
        chk("restart_done_edge", ea, 11);
        chk("restart_csum", a_csum, 16'hAAAA);
        chk("restart_left", exp_fl_q.size() + exp_sr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
